efb_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single EFB Wishbone slave port (hard SPI master) between the SD/ADC `spi_controller` and a second requester, such as a configuration or thermal-sensor SPI sequencer. It sits between the masters and `efb` on the `clock_84_0000` domain. Each master holds its grant for as long as it keeps `cyc` high, so multi-transfer SPI sequences are never interleaved. Ties are broken round-robin, and an optional ack watchdog frees the bus if the EFB stops acknowledging.

---
 rtl/efb_wb_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_efb_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/efb_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the EFB slave; grant 1 cycle after cyc, data/ack paths combinational.
// Owner holds the bus while cyc stays high; EFB_WB_ARB_TIMEOUT_EN adds an ack watchdog with error recovery.
module efb_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       m0_cyc,
    input  logic       m0_stb,
    input  logic       m0_we,
    input  logic [7:0] m0_adr,
    input  logic [7:0] m0_wdat,
    output logic [7:0] m0_rdat,
    output logic       m0_ack,
    output logic       m0_err,
    input  logic       m1_cyc,
    input  logic       m1_stb,
    input  logic       m1_we,
    input  logic [7:0] m1_adr,
    input  logic [7:0] m1_wdat,
    output logic [7:0] m1_rdat,
    output logic       m1_ack,
    output logic       m1_err,
    output logic       s_cyc,
    output logic       s_stb,
    output logic       s_we,
    output logic [7:0] s_adr,
    output logic [7:0] s_wdat,
    input  logic [7:0] s_rdat,
    input  logic       s_ack,
    output logic [1:0] grant,
    output logic       timeout_error
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("efb_wb_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

`ifdef EFB_WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, RECOVER} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
`endif

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   own0, own1;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

`ifdef EFB_WB_ARB_TIMEOUT_EN
    // Terminal value is one less than the limit: the limit-th stalled cycle trips it.
    localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic        tout_q, tout_d;
    logic        rec_m1_q, rec_m1_d;
    logic        stall;

    assign stall = s_stb & ~s_ack;
`endif

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
`ifdef EFB_WB_ARB_TIMEOUT_EN
        cnt_d    = '0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        tout_d   = tout_q;
        rec_m1_d = rec_m1_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    if (last_owner_q) begin
                        state_d      = OWN0;
                        last_owner_d = 1'b0;
                    end else begin
                        state_d      = OWN1;
                        last_owner_d = 1'b1;
                    end
                end else if (m0_cyc) begin
                    state_d = OWN0;
                end else if (m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc) begin
                    state_d = IDLE;
                end
`ifdef EFB_WB_ARB_TIMEOUT_EN
                else if (stall) begin
                    if (cnt_q == TC_LAST) begin
                        state_d  = RECOVER;
                        err0_d   = 1'b1;
                        tout_d   = 1'b1;
                        rec_m1_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`endif
            end
            OWN1: begin
                if (!m1_cyc) begin
                    state_d = IDLE;
                end
`ifdef EFB_WB_ARB_TIMEOUT_EN
                else if (stall) begin
                    if (cnt_q == TC_LAST) begin
                        state_d  = RECOVER;
                        err1_d   = 1'b1;
                        tout_d   = 1'b1;
                        rec_m1_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`endif
            end
`ifdef EFB_WB_ARB_TIMEOUT_EN
            RECOVER: begin
                if (!(rec_m1_q ? m1_cyc : m0_cyc)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
`ifdef EFB_WB_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            tout_q   <= 1'b0;
            rec_m1_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
`ifdef EFB_WB_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            tout_q   <= tout_d;
            rec_m1_q <= rec_m1_d;
`endif
        end
    end

    // stb is gated by cyc so a stray strobe never reaches the EFB.
    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_adr  = 8'h00;
        s_wdat = 8'h00;
        if (own0) begin
            s_cyc  = m0_cyc;
            s_stb  = m0_cyc & m0_stb;
            s_we   = m0_we;
            s_adr  = m0_adr;
            s_wdat = m0_wdat;
        end else if (own1) begin
            s_cyc  = m1_cyc;
            s_stb  = m1_cyc & m1_stb;
            s_we   = m1_we;
            s_adr  = m1_adr;
            s_wdat = m1_wdat;
        end
    end

    assign m0_ack  = own0 & s_ack;
    assign m1_ack  = own1 & s_ack;
    assign m0_rdat = own0 ? s_rdat : 8'h00;
    assign m1_rdat = own1 ? s_rdat : 8'h00;
    assign grant   = {own1, own0};

`ifdef EFB_WB_ARB_TIMEOUT_EN
    assign m0_err        = err0_q;
    assign m1_err        = err1_q;
    assign timeout_error = tout_q;
`else
    assign m0_err        = 1'b0;
    assign m1_err        = 1'b0;
    assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Directed bench for efb_wb_arbiter: write, tie-break, hold, read isolation, watchdog and mid-transfer reset.
module tb_efb_wb_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       m0_cyc, m0_stb, m0_we;
    logic [7:0] m0_adr, m0_wdat, m0_rdat;
    logic       m0_ack, m0_err;
    logic       m1_cyc, m1_stb, m1_we;
    logic [7:0] m1_adr, m1_wdat, m1_rdat;
    logic       m1_ack, m1_err;
    logic       s_cyc, s_stb, s_we;
    logic [7:0] s_adr, s_wdat, s_rdat;
    logic       s_ack;
    logic [1:0] grant;
    logic       timeout_error;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    efb_wb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_wdat(m0_wdat), .m0_rdat(m0_rdat), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_wdat(m1_wdat), .m1_rdat(m1_rdat), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_wdat(s_wdat), .s_rdat(s_rdat), .s_ack(s_ack),
        .grant(grant), .timeout_error(timeout_error)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let the outputs settle before anything is checked or driven.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 8'h00; m0_wdat = 8'h00;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 8'h00; m1_wdat = 8'h00;
        s_rdat = 8'h00; s_ack = 1'b0;
        step();
        step();
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_s_cyc", 8'(s_cyc), 8'h00);
        chk("rst_tout", 8'(timeout_error), 8'h00);
        chk("rst_m0_err", 8'(m0_err), 8'h00);
        reset = 1'b0;

        // single write from m0, ack three cycles after the grant cycle
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 8'h59; m0_wdat = 8'hA5;
        #1;
        chk("wr_idle_grant", 8'(grant), 8'h00);
        chk("wr_idle_s_cyc", 8'(s_cyc), 8'h00);
        step();
        chk("wr_grant", 8'(grant), 8'h01);
        chk("wr_s_cyc", 8'(s_cyc), 8'h01);
        chk("wr_s_stb", 8'(s_stb), 8'h01);
        chk("wr_s_we", 8'(s_we), 8'h01);
        chk("wr_s_adr", s_adr, 8'h59);
        chk("wr_s_wdat", s_wdat, 8'hA5);
        chk("wr_no_ack_yet", 8'(m0_ack), 8'h00);
        step(); step(); step();
        s_ack = 1'b1;
        #1;
        chk("wr_m0_ack", 8'(m0_ack), 8'h01);
        chk("wr_m1_ack", 8'(m1_ack), 8'h00);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        #1;
        chk("wr_ack_done", 8'(m0_ack), 8'h00);
        chk("wr_drop_s_cyc", 8'(s_cyc), 8'h00);
        step();
        chk("wr_release_grant", 8'(grant), 8'h00);

        // tie after reset: m0 first, one idle cycle, then m1
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 8'h11;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 8'h22;
        step();
        chk("tie1_grant", 8'(grant), 8'h01);
        chk("tie1_s_adr", s_adr, 8'h11);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        chk("tie1_gap_grant", 8'(grant), 8'h00);
        chk("tie1_gap_s_cyc", 8'(s_cyc), 8'h00);
        step();
        chk("tie1_m1_grant", 8'(grant), 8'h02);
        chk("tie1_m1_s_adr", s_adr, 8'h22);
        // read isolation while m1 owns
        s_rdat = 8'h3C; s_ack = 1'b1;
        #1;
        chk("rd_m1_rdat", m1_rdat, 8'h3C);
        chk("rd_m0_rdat", m0_rdat, 8'h00);
        chk("rd_m1_ack", 8'(m1_ack), 8'h01);
        chk("rd_m0_ack", 8'(m0_ack), 8'h00);
        step();
        s_ack = 1'b0; s_rdat = 8'h00; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        chk("tie1_end_grant", 8'(grant), 8'h00);
        // second tie goes to m1
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        chk("tie2_grant", 8'(grant), 8'h02);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        step();
        chk("tie2_end_grant", 8'(grant), 8'h00);

        // m1 holds the bus across three transfers while m0 waits
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        chk("hold_grant", 8'(grant), 8'h02);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            s_ack = 1'b1;
            #1;
            chk("hold_m1_ack", 8'(m1_ack), 8'h01);
            chk("hold_m0_ack", 8'(m0_ack), 8'h00);
            chk("hold_grant_kept", 8'(grant), 8'h02);
            step();
            s_ack = 1'b0;
        end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        chk("hold_gap_grant", 8'(grant), 8'h00);
        step();
        chk("hold_m0_grant", 8'(grant), 8'h01);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();

        // watchdog: m0 strobes, slave never acks
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        chk("wd_grant", 8'(grant), 8'h01);
`ifdef EFB_WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("wd_no_err_yet", 8'(m0_err), 8'h00);
        chk("wd_stb_still", 8'(s_stb), 8'h01);
        step();
        chk("wd_m0_err", 8'(m0_err), 8'h01);
        chk("wd_m1_err", 8'(m1_err), 8'h00);
        chk("wd_tout", 8'(timeout_error), 8'h01);
        chk("wd_rec_s_cyc", 8'(s_cyc), 8'h00);
        chk("wd_rec_grant", 8'(grant), 8'h00);
        step();
        chk("wd_err_pulse", 8'(m0_err), 8'h00);
        chk("wd_rec_hold", 8'(s_cyc), 8'h00);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        chk("wd_idle_grant", 8'(grant), 8'h00);
        chk("wd_tout_sticky", 8'(timeout_error), 8'h01);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        chk("wd_regrant", 8'(grant), 8'h01);
`else
        for (int i = 0; i < 100; i++) step();
        chk("wd_off_stb", 8'(s_stb), 8'h01);
        chk("wd_off_grant", 8'(grant), 8'h01);
        chk("wd_off_err", 8'(m0_err), 8'h00);
        chk("wd_off_tout", 8'(timeout_error), 8'h00);
`endif
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();

        // reset while m1 is mid-transfer
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        chk("mrst_grant", 8'(grant), 8'h02);
        chk("mrst_s_stb", 8'(s_stb), 8'h01);
        reset = 1'b1;
        step();
        chk("mrst_grant_after", 8'(grant), 8'h00);
        chk("mrst_s_cyc", 8'(s_cyc), 8'h00);
        chk("mrst_tout", 8'(timeout_error), 8'h00);
        chk("mrst_m1_ack", 8'(m1_ack), 8'h00);
        reset = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        chk("mrst_tie_grant", 8'(grant), 8'h01);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
